// File: rtl/nios2_dbg_cmd_sysclk.sv
// JTAG debug command bridge: synchronises update-DR/IR levels into the system clock and queues commands.
// Define DBG_CMD_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module nios2_dbg_cmd_sysclk #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             sr,
  input  logic [IR_W-1:0]               ir_in,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic                          cmd_ready,
  input  logic                          clr_overflow,
  output logic                          cmd_valid,
  output logic [DATA_W-1:0]             jdo,
  output logic [IR_W-1:0]               jir,
  output logic [(1<<IR_W)-1:0]          take_action,
  output logic [(1<<IR_W)-1:0]          take_no_action,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int NCMD  = 1 << IR_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = IR_W + DATA_W;
`ifdef DBG_CMD_FIFO_EN
  localparam int DEPTH_EFF = FIFO_DEPTH;
`else
  localparam int DEPTH_EFF = 1;
`endif

  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_dly_q, uir_dly_q;
  logic                   push_q, ir_load_q;

  // Stages reset high so a level already asserted at reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_q <= '1;
      uir_sync_q <= '1;
      udr_dly_q  <= 1'b1;
      uir_dly_q  <= 1'b1;
      push_q     <= 1'b0;
      ir_load_q  <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_dly_q  <= udr_sync_q[SYNC_STAGES-1];
      uir_dly_q  <= uir_sync_q[SYNC_STAGES-1];
      push_q     <= udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q;
      ir_load_q  <= uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q;
    end
  end

  logic [ENT_W-1:0] entry, head;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [IR_W-1:0]  ir_lat_q;
  logic             pop, full, push_ok, drop;

  assign entry     = {ir_lat_q, sr};
  assign cmd_valid = (count_q != '0);
  assign pop       = cmd_valid & cmd_ready;
  assign full      = (count_q == CNT_W'(DEPTH_EFF));
  assign push_ok   = push_q & (~full | pop);
  assign drop      = push_q & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push_ok)
      count_d = count_q - CNT_W'(1);
    overflow_d = overflow_q;
    if (drop)
      overflow_d = 1'b1;
    else if (clr_overflow)
      overflow_d = 1'b0;
  end

`ifdef DBG_CMD_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end
`else
  logic [ENT_W-1:0] hold_q;

  assign head = hold_q;

  // A push on a popping edge overwrites the entry being read out, which is what keeps depth 1 streaming.
  always_ff @(posedge clk) begin
    if (push_ok)
      hold_q <= entry;
  end
`endif

  logic [NCMD-1:0]   sel, act_q, noact_q;
  logic [DATA_W-1:0] jdo_q;
  logic [IR_W-1:0]   jir_q;

  assign sel = NCMD'(1) << head[ENT_W-1 -: IR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      ir_lat_q   <= '0;
      jdo_q      <= '0;
      jir_q      <= '0;
      act_q      <= '0;
      noact_q    <= '0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      act_q      <= '0;
      noact_q    <= '0;
      if (ir_load_q)
        ir_lat_q <= ir_in;
      if (pop) begin
        jdo_q <= head[DATA_W-1:0];
        jir_q <= head[ENT_W-1 -: IR_W];
        if (head[DATA_W-1])
          act_q <= sel;
        else
          noact_q <= sel;
      end
    end
  end

  assign jdo            = jdo_q;
  assign jir            = jir_q;
  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign overflow       = overflow_q;
  assign count          = count_q;

endmodule

// File: tb/tb_nios2_dbg_cmd_sysclk.sv
// Scoreboard bench for nios2_dbg_cmd_sysclk; expectations follow the queue depth selected by DBG_CMD_FIFO_EN.
module tb_nios2_dbg_cmd_sysclk;

  localparam int DATA_W      = 38;
  localparam int IR_W        = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int NCMD        = 1 << IR_W;
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int HOLD        = SYNC_STAGES + 3;
`ifdef DBG_CMD_FIFO_EN
  localparam int DEPTH_EFF = FIFO_DEPTH;
`else
  localparam int DEPTH_EFF = 1;
`endif

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] sr;
  logic [IR_W-1:0]   ir_in;
  logic              vs_udr, vs_uir, cmd_ready, clr_overflow;
  logic              cmd_valid;
  logic [DATA_W-1:0] jdo;
  logic [IR_W-1:0]   jir;
  logic [NCMD-1:0]   take_action, take_no_action;
  logic              overflow;
  logic [CNT_W-1:0]  count;

  logic [IR_W+DATA_W-1:0] expQ[$];
  logic [IR_W-1:0]        irModel;
  int compared   = 0;
  int mismatched = 0;

  nios2_dbg_cmd_sysclk #(
    .DATA_W(DATA_W), .IR_W(IR_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .cmd_ready(cmd_ready), .clr_overflow(clr_overflow), .cmd_valid(cmd_valid), .jdo(jdo),
    .jir(jir), .take_action(take_action), .take_no_action(take_no_action),
    .overflow(overflow), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every handshake edge pops the oldest expected command and checks the registered outputs just after it.
  always @(posedge clk) begin : monitor
    logic                   hs;
    logic [IR_W+DATA_W-1:0] exp;
    logic [NCMD-1:0]        expAct, expNoAct;
    hs = (cmd_valid === 1'b1) && (cmd_ready === 1'b1) && (reset === 1'b0);
    #1;
    if (hs) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_pop got jdo=%h want no pop", jdo);
      end else begin
        exp      = expQ.pop_front();
        expAct   = '0;
        expNoAct = '0;
        if (exp[DATA_W-1]) expAct = NCMD'(1) << exp[IR_W+DATA_W-1 -: IR_W];
        else               expNoAct = NCMD'(1) << exp[IR_W+DATA_W-1 -: IR_W];
        if (jdo !== exp[DATA_W-1:0]) begin
          mismatched++;
          $display("[TB] FAIL pop_jdo got=%h want=%h", jdo, exp[DATA_W-1:0]);
        end
        compared++;
        if (jir !== exp[IR_W+DATA_W-1 -: IR_W]) begin
          mismatched++;
          $display("[TB] FAIL pop_jir got=%0d want=%0d", jir, exp[IR_W+DATA_W-1 -: IR_W]);
        end
        compared++;
        if (take_action !== expAct || take_no_action !== expNoAct) begin
          mismatched++;
          $display("[TB] FAIL pop_strobe got act=%b noact=%b want act=%b noact=%b",
                   take_action, take_no_action, expAct, expNoAct);
        end
      end
    end else begin
      compared++;
      if (take_action !== '0 || take_no_action !== '0) begin
        mismatched++;
        $display("[TB] FAIL idle_strobe got act=%b noact=%b want 0", take_action, take_no_action);
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_push(input logic [DATA_W-1:0] d, input bit forceAccept);
    if (forceAccept || expQ.size() < DEPTH_EFF)
      expQ.push_back({irModel, d});
  endtask

  // concPop raises cmd_ready for exactly the edge on which the push lands.
  task automatic pulse_udr(input logic [DATA_W-1:0] d, input bit concPop);
    @(negedge clk);
    sr     = d;
    vs_udr = 1'b1;
    model_push(d, concPop);
    wait_neg(SYNC_STAGES + 1);
    if (concPop) cmd_ready = 1'b1;
    wait_neg(1);
    if (concPop) cmd_ready = 1'b0;
    wait_neg(HOLD - SYNC_STAGES - 2);
    vs_udr = 1'b0;
    wait_neg(HOLD);
  endtask

  task automatic pulse_uir(input logic [IR_W-1:0] ir);
    @(negedge clk);
    ir_in   = ir;
    vs_uir  = 1'b1;
    irModel = ir;
    wait_neg(HOLD);
    vs_uir = 1'b0;
    wait_neg(HOLD);
  endtask

  task automatic check_count(input string name, input int want);
    compared++;
    if (count !== CNT_W'(want)) begin
      mismatched++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, count, want);
    end
  endtask

  task automatic check_ovf(input string name, input logic want);
    compared++;
    if (overflow !== want) begin
      mismatched++;
      $display("[TB] FAIL %s got=%b want=%b", name, overflow, want);
    end
  endtask

  task automatic drain(input string name);
    cmd_ready = 1'b1;
    for (int i = 0; i < 50 && expQ.size() != 0; i++) @(negedge clk);
    wait_neg(2);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL %s_drain got %0d entries left want 0", name, expQ.size());
    end
    check_count({name, "_empty"}, 0);
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    wait_neg(3);
    compared++;
    if ({cmd_valid, count, overflow, jir, take_action, take_no_action} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl got valid=%b cnt=%0d ovf=%b jir=%0d act=%b noact=%b want all 0",
               cmd_valid, count, overflow, jir, take_action, take_no_action);
    end
    compared++;
    if (jdo !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_jdo got=%h want=0", jdo);
    end
    reset = 1'b0;
    wait_neg(HOLD);
    check_count("reset_release_cnt", 0);
  endtask

  task automatic test_single_cmd();
    cmd_ready = 1'b1;
    pulse_uir(2'd1);
    pulse_udr(38'h20_0000_00AB, 1'b0);
    drain("single");
    compared++;
    if (jdo !== 38'h20_0000_00AB) begin
      mismatched++;
      $display("[TB] FAIL single_jdo_hold got=%h want=%h", jdo, 38'h20_0000_00AB);
    end
  endtask

  task automatic test_overflow();
    cmd_ready = 1'b0;
    for (int i = 1; i <= DEPTH_EFF + 1; i++) pulse_udr(DATA_W'(i), 1'b0);
    check_count("ovf_count", DEPTH_EFF);
    check_ovf("ovf_set", 1'b1);
    drain("ovf");
    check_ovf("ovf_sticky", 1'b1);
    @(negedge clk) clr_overflow = 1'b1;
    @(negedge clk) clr_overflow = 1'b0;
    check_ovf("ovf_clear", 1'b0);
  endtask

  task automatic test_back_to_back();
    cmd_ready = 1'b0;
    for (int i = 0; i < DEPTH_EFF; i++) pulse_udr(DATA_W'(16 + i), 1'b0);
    check_count("b2b_full", DEPTH_EFF);
    pulse_udr(38'h20_0000_0055, 1'b1);
    check_count("b2b_count_kept", DEPTH_EFF);
    check_ovf("b2b_no_ovf", 1'b0);
    drain("b2b");
  endtask

  task automatic test_coincident();
    cmd_ready = 1'b1;
    @(negedge clk);
    ir_in  = 2'd3;
    sr     = 38'h0A_0000_0C0A;
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    model_push(38'h0A_0000_0C0A, 1'b0);
    irModel = 2'd3;
    wait_neg(HOLD);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    wait_neg(HOLD);
    pulse_udr(38'h2B_0000_0B0B, 1'b0);
    drain("coinc");
  endtask

  task automatic test_reset_midop();
    cmd_ready = 1'b0;
    pulse_udr(38'h77, 1'b0);
    check_count("mid_queued", 1);
    @(negedge clk);
    vs_udr = 1'b1;
    reset  = 1'b1;
    expQ.delete();
    irModel = '0;
    wait_neg(3);
    check_count("mid_reset_cnt", 0);
    compared++;
    if (cmd_valid !== 1'b0 || jdo !== '0 || jir !== '0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_out got valid=%b jdo=%h jir=%0d want 0", cmd_valid, jdo, jir);
    end
    reset = 1'b0;
    wait_neg(HOLD + 3);
    check_count("high_at_release_cnt", 0);
    vs_udr = 1'b0;
    wait_neg(HOLD);
    pulse_udr(38'h20_0000_0099, 1'b0);
    check_count("after_release_push", 1);
    drain("release");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    sr           = '0;
    ir_in        = '0;
    vs_udr       = 1'b0;
    vs_uir       = 1'b0;
    cmd_ready    = 1'b0;
    clr_overflow = 1'b0;
    irModel      = '0;
    test_reset();
    test_single_cmd();
    test_overflow();
    test_back_to_back();
    test_coincident();
    test_reset_midop();
    wait_neg(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
